// File: rtl/mem_store_buffer_unit_if.sv
// Bus bundle for the memory-stage store buffer: pipeline-side request/response
// signals plus the data-cache handshake. The unit uses the slave modport; the
// environment around it (pipeline and cache) uses the master modport.
interface mem_store_buffer_unit_if #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
);
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  logic              mem_read_en;
  logic              mem_write_en;
  logic              fence;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       write_data;
  logic [2:0]        func3;
  logic [31:0]       read_data;
  logic              mem_busywait;
  logic              misalign;
  logic [CNT_W-1:0]  sb_count;

  logic              dc_read;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_addr;
  logic [31:0]       dc_writedata;
  logic [3:0]        dc_byte_en;
  logic [31:0]       dc_readdata;
  logic              dc_busywait;

  modport master (
    output mem_read_en, mem_write_en, fence, addr, write_data, func3,
    output dc_readdata, dc_busywait,
    input  read_data, mem_busywait, misalign, sb_count,
    input  dc_read, dc_write, dc_addr, dc_writedata, dc_byte_en
  );

  modport slave (
    input  mem_read_en, mem_write_en, fence, addr, write_data, func3,
    input  dc_readdata, dc_busywait,
    output read_data, mem_busywait, misalign, sb_count,
    output dc_read, dc_write, dc_addr, dc_writedata, dc_byte_en
  );
endinterface

// File: rtl/mem_store_buffer_unit.sv
// Memory-stage unit with a circular store buffer between the pipeline and the
// data cache. Stores retire into the buffer, younger loads forward from the
// youngest matching entry, and a small FSM drains entries or services load
// misses through the cache busywait handshake.
module mem_store_buffer_unit #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  mem_store_buffer_unit_if.slave bus
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SB_DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, LDONE} state_t;

  state_t            state;
  state_t            next_state;

  logic [WA_W-1:0]   sb_addr [SB_DEPTH];
  logic [31:0]       sb_data [SB_DEPTH];
  logic [3:0]        sb_be   [SB_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [31:0]       load_word;

  logic [1:0]        byte_off;
  logic [WA_W-1:0]   word_addr;
  logic              bad_func;
  logic              bad_align;
  logic [3:0]        need_be;
  logic [31:0]       lane_data;
  logic              misalign;
  logic              load_ok;
  logic              store_ok;

  logic              found;
  logic [PTR_W-1:0]  hit_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic              covered;
  logic              fwd_hit;
  logic              partial;
  logic              miss_pending;
  logic              store_full;
  logic              enq;
  logic              pop;

  logic [31:0]       src_word;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       read_data;

  logic              dc_read_q;
  logic              dc_write_q;
  logic [ADDR_W-1:0] dc_addr_q;
  logic [31:0]       dc_writedata_q;
  logic [3:0]        dc_byte_en_q;

  assign byte_off  = bus.addr[1:0];
  assign word_addr = bus.addr[ADDR_W-1:2];

  // Decode access size: lane enables, replicated store data and legality.
  always_comb begin
    bad_func  = 1'b0;
    bad_align = 1'b0;
    need_be   = 4'b0000;
    lane_data = 32'h0;
    case (bus.func3)
      3'b000: begin
        need_be   = 4'b0001 << byte_off;
        lane_data = {4{bus.write_data[7:0]}};
      end
      3'b001: begin
        bad_align = byte_off[0];
        need_be   = 4'b0011 << byte_off;
        lane_data = {2{bus.write_data[15:0]}};
      end
      3'b010: begin
        bad_align = (byte_off != 2'b00);
        need_be   = 4'b1111;
        lane_data = bus.write_data;
      end
      3'b100: begin
        bad_func = bus.mem_write_en;
        need_be  = 4'b0001 << byte_off;
      end
      3'b101: begin
        bad_func  = bus.mem_write_en;
        bad_align = byte_off[0];
        need_be   = 4'b0011 << byte_off;
      end
      default: bad_func = 1'b1;
    endcase
  end

  assign misalign = (bus.mem_read_en | bus.mem_write_en) & (bad_func | bad_align);
  assign load_ok  = bus.mem_read_en & ~misalign;
  assign store_ok = bus.mem_write_en & ~misalign;

  // Scan valid entries oldest to youngest so the last match is the youngest.
  always_comb begin
    found    = 1'b0;
    hit_idx  = head;
    scan_idx = head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (sb_addr[scan_idx] == word_addr)) begin
        found   = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign covered      = ((sb_be[hit_idx] & need_be) == need_be);
  assign fwd_hit      = load_ok & found & covered;
  assign partial      = load_ok & found & ~covered;
  assign miss_pending = load_ok & ~found;
  assign store_full   = store_ok & (count == FULL);
  assign enq          = store_ok & (count != FULL);
  assign pop          = (state == DRAIN) & ~bus.dc_busywait;

  assign bus.mem_busywait = store_full | partial
                          | (miss_pending & (state != LDONE))
                          | (bus.fence & ((count != '0) | (state != IDLE)));

  assign src_word = (state == LDONE) ? load_word
                  : (fwd_hit ? sb_data[hit_idx] : load_word);
  assign sel_byte = src_word[{byte_off, 3'b000} +: 8];
  assign sel_half = src_word[{byte_off[1], 4'b0000} +: 16];

  // Select and extend the loaded byte/half/word; illegal accesses read zero.
  always_comb begin
    read_data = 32'h0;
    if (load_ok) begin
      case (bus.func3)
        3'b000:  read_data = {{24{sel_byte[7]}}, sel_byte};
        3'b001:  read_data = {{16{sel_half[15]}}, sel_half};
        3'b010:  read_data = src_word;
        3'b100:  read_data = {24'h0, sel_byte};
        3'b101:  read_data = {16'h0, sel_half};
        default: read_data = 32'h0;
      endcase
    end
  end

  assign bus.read_data = read_data;
  assign bus.misalign  = misalign;
  assign bus.sb_count  = count;

  // Write an accepted store into the tail slot; stale slots are never read.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr[tail] <= word_addr;
      sb_data[tail] <= lane_data;
      sb_be[tail]   <= need_be;
    end
  end

  // Advance FIFO pointers and occupancy on enqueue and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: a pending miss load wins over draining in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (miss_pending)        next_state = LOAD;
        else if (count != '0)    next_state = DRAIN;
      end
      DRAIN: if (!bus.dc_busywait) next_state = IDLE;
      LOAD:  if (!bus.dc_busywait) next_state = LDONE;
      LDONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Register cache request outputs from the upcoming state so they hold steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_read_q      <= 1'b0;
      dc_write_q     <= 1'b0;
      dc_addr_q      <= '0;
      dc_writedata_q <= 32'h0;
      dc_byte_en_q   <= 4'h0;
    end else begin
      dc_read_q  <= (next_state == LOAD);
      dc_write_q <= (next_state == DRAIN);
      case (next_state)
        DRAIN: begin
          dc_addr_q      <= {sb_addr[head], 2'b00};
          dc_writedata_q <= sb_data[head];
          dc_byte_en_q   <= sb_be[head];
        end
        LOAD: begin
          dc_addr_q      <= {word_addr, 2'b00};
          dc_writedata_q <= 32'h0;
          dc_byte_en_q   <= 4'h0;
        end
        default: begin
          dc_addr_q      <= '0;
          dc_writedata_q <= 32'h0;
          dc_byte_en_q   <= 4'h0;
        end
      endcase
    end
  end

  // Capture the cache word at read completion for the LDONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  load_word <= 32'h0;
    else if ((state == LOAD) && !bus.dc_busywait) load_word <= bus.dc_readdata;
  end

  assign bus.dc_read      = dc_read_q;
  assign bus.dc_write     = dc_write_q;
  assign bus.dc_addr      = dc_addr_q;
  assign bus.dc_writedata = dc_writedata_q;
  assign bus.dc_byte_en   = dc_byte_en_q;

endmodule

// File: tb/tb_mem_store_buffer_unit.sv
// Bench for mem_store_buffer_unit: a behavioural cache with programmable
// busywait, an architectural memory model for load results, and a queue of
// expected cache writes compared as the unit drains them.
module tb_mem_store_buffer_unit;
  localparam int SB_DEPTH = 4;
  localparam int ADDR_W   = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  mem_store_buffer_unit_if #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W)) bus();

  mem_store_buffer_unit #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          cache_wait = 0;
  int          wait_cnt = 0;
  int          wr_done  = 0;
  int          rd_done  = 0;
  int          wr_cyc[$];
  logic [31:0] last_rd_addr = 32'h0;
  logic [31:0] arch_mem  [256];
  logic [31:0] cache_mem [256];
  wr_t         exp_wr[$];
  logic [31:0] exp_ld[$];
  wr_t         got_e;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic exp_misalign(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3);
    if (!rd && !wr) return 1'b0;
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return (a[1:0] != 2'b00);
      3'b100:  return wr;
      3'b101:  return wr | a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return word;
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic wr_t exp_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    wr_t e;
    e.addr = {a[31:2], 2'b00};
    case (f3)
      3'b000:  begin e.be = 4'b0001 << a[1:0]; e.data = {4{wd[7:0]}}; end
      3'b001:  begin e.be = 4'b0011 << a[1:0]; e.data = {2{wd[15:0]}}; end
      default: begin e.be = 4'b1111; e.data = wd; end
    endcase
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Cache model: drive busywait and read data half a cycle after the request.
  initial begin
    bus.dc_busywait = 1'b0;
    bus.dc_readdata = 32'h0;
    for (int i = 0; i < 256; i++) cache_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
    forever begin
      @(negedge clk);
      if (bus.dc_read || bus.dc_write) begin
        if (wait_cnt < cache_wait) begin
          bus.dc_busywait = 1'b1;
          wait_cnt++;
        end else begin
          bus.dc_busywait = 1'b0;
        end
        bus.dc_readdata = cache_mem[bus.dc_addr[9:2]];
      end else begin
        bus.dc_busywait = 1'b0;
        bus.dc_readdata = 32'h0;
        wait_cnt = 0;
      end
    end
  end

  // Cache completions: pop and compare expected writes in program order.
  always @(posedge clk) begin
    if (rst_n && bus.dc_write && !bus.dc_busywait) begin
      wr_done++;
      wr_cyc.push_back(cyc);
      if (exp_wr.size() == 0) begin
        checkOutput("dc write queue size", 0, 1);
      end else begin
        got_e = exp_wr.pop_front();
        checkOutput("dc write addr", bus.dc_addr, got_e.addr);
        checkOutput("dc write data", bus.dc_writedata, got_e.data);
        checkOutput("dc write be", {28'h0, bus.dc_byte_en}, {28'h0, got_e.be});
      end
      for (int b = 0; b < 4; b++)
        if (bus.dc_byte_en[b]) cache_mem[bus.dc_addr[9:2]][8*b +: 8] = bus.dc_writedata[8*b +: 8];
    end
    if (rst_n && bus.dc_read && !bus.dc_busywait) begin
      rd_done++;
      last_rd_addr = bus.dc_addr;
    end
  end

  // Drive one MEM-stage operation, wait out its stall, check and retire it.
  task automatic applyStimulus(input logic rd, input logic wr, input logic fn,
                               input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                               input string tag, output int stalls, output int accept_cyc);
    logic mis;
    wr_t  e;
    mis = exp_misalign(rd, wr, a, f3);
    bus.mem_read_en  = rd;
    bus.mem_write_en = wr;
    bus.fence        = fn;
    bus.addr         = a;
    bus.write_data   = wd;
    bus.func3        = f3;
    if (rd) exp_ld.push_back(mis ? 32'h0 : exp_load(arch_mem[a[9:2]], a, f3));
    stalls = 0;
    @(negedge clk);
    checkOutput({tag, " misalign"}, {31'h0, bus.misalign}, {31'h0, mis});
    while (bus.mem_busywait === 1'b1 && stalls < 300) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 300) checkOutput({tag, " stall bound"}, {31'h0, bus.mem_busywait}, 0);
    if (rd) checkOutput({tag, " read_data"}, bus.read_data, exp_ld.pop_front());
    @(posedge clk);
    accept_cyc = cyc;
    if (wr && !mis) begin
      e = exp_store(a, wd, f3);
      exp_wr.push_back(e);
      for (int b = 0; b < 4; b++)
        if (e.be[b]) arch_mem[a[9:2]][8*b +: 8] = e.data[8*b +: 8];
    end
    #1;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.fence        = 1'b0;
  endtask

  // Let the buffer empty and the cache go quiet before the next scenario.
  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.sb_count != 0 || bus.dc_write || bus.dc_read) && n < 300) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, " drained count"}, {29'h0, bus.sb_count}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int          st;
  int          ac;
  int          st5;
  int          ac5;
  int          mark;
  int          n;
  logic [31:0] ra;
  logic [2:0]  rf3;
  logic        isld;
  int          sz;

  initial begin
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.fence        = 1'b0;
    bus.addr         = 32'h0;
    bus.write_data   = 32'h0;
    bus.func3        = 3'b000;
    for (int i = 0; i < 256; i++) arch_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);

    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset read_data", bus.read_data, 0);
    checkOutput("reset busywait", {31'h0, bus.mem_busywait}, 0);
    checkOutput("reset misalign", {31'h0, bus.misalign}, 0);
    checkOutput("reset sb_count", {29'h0, bus.sb_count}, 0);
    checkOutput("reset dc_read", {31'h0, bus.dc_read}, 0);
    checkOutput("reset dc_write", {31'h0, bus.dc_write}, 0);
    checkOutput("reset dc_addr", bus.dc_addr, 0);
    checkOutput("reset dc_writedata", bus.dc_writedata, 0);
    checkOutput("reset dc_byte_en", {28'h0, bus.dc_byte_en}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] store-to-load forward");
    cache_wait = 3;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 3'b010, "sw 0x100", st, ac);
    mark = rd_done;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 3'b010, "lw fwd", st, ac);
    checkOutput("lw fwd stalls", st, 0);
    waitDrain("fwd");
    checkOutput("lw fwd no dc read", rd_done, mark);

    $display("[TB] byte forward and partial hazard");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h103, 32'hABCD_1280, 3'b000, "sb 0x103", st, ac);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h103, 32'h0, 3'b000, "lb fwd", st, ac);
    checkOutput("lb fwd stalls", st, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h103, 32'h0, 3'b100, "lbu fwd", st, ac);
    checkOutput("lbu fwd stalls", st, 0);
    mark = rd_done;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 3'b001, "lh partial", st, ac);
    checkOutput("lh partial stalled", {31'h0, (st > 0)}, 1);
    checkOutput("lh partial one read", rd_done, mark + 1);
    checkOutput("lh partial read addr", last_rd_addr, 32'h100);
    checkOutput("lh partial writes drained", exp_wr.size(), 0);

    $display("[TB] misaligned and illegal accesses");
    mark = rd_done;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 3'b010, "lw 0x102", st, ac);
    checkOutput("lw misaligned stalls", st, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h101, 32'h1234, 3'b001, "sh 0x101", st, ac);
    checkOutput("sh misaligned count", {29'h0, bus.sb_count}, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 3'b011, "load f3=3", st, ac);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h104, 32'h77, 3'b100, "store f3=4", st, ac);
    repeat (3) @(negedge clk);
    checkOutput("misaligned no dc read", rd_done, mark);
    checkOutput("misaligned no dc write", {31'h0, bus.dc_write}, 0);
    @(posedge clk);
    #1;

    $display("[TB] full buffer with pointer wrap");
    cache_wait = 3;
    wr_cyc.delete();
    st5 = 0;
    ac5 = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h140 + 32'(4 * k), 32'h1111_0000 + 32'(k), 3'b010, "sw full", st, ac);
      if (k < 4) checkOutput("sw full early stalls", st, 0);
      else begin
        st5 = st;
        ac5 = ac;
      end
    end
    checkOutput("fifth store stalled", {31'h0, (st5 > 0)}, 1);
    if (wr_cyc.size() == 0) checkOutput("first pop seen", 0, 1);
    else checkOutput("fifth store accept cycle", ac5, wr_cyc[0] + 1);
    waitDrain("full");
    checkOutput("full writes all seen", exp_wr.size(), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h150, 32'h0, 3'b010, "lw after wrap", st, ac);

    $display("[TB] fence");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h180, 32'hA0A0_0001, 3'b010, "sw fence a", st, ac);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h184, 32'hA0A0_0002, 3'b010, "sw fence b", st, ac);
    checkOutput("fence entries buffered", {29'h0, bus.sb_count}, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 3'b000, "fence", st, ac);
    checkOutput("fence stalled", {31'h0, (st > 0)}, 1);
    checkOutput("fence released empty", {29'h0, bus.sb_count}, 0);
    checkOutput("fence released no write", {31'h0, bus.dc_write}, 0);

    $display("[TB] mixed random traffic");
    for (int k = 0; k < 40; k++) begin
      cache_wait = $urandom_range(0, 2);
      isld = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 2);
      ra = 32'h200 + 32'(4 * $urandom_range(0, 3));
      if (sz == 0) ra = ra + 32'($urandom_range(0, 3));
      else if (sz == 1) ra = ra + 32'(2 * $urandom_range(0, 1));
      rf3 = 3'(sz);
      if (isld && sz < 2 && $urandom_range(0, 1) == 1) rf3[2] = 1'b1;
      applyStimulus(isld, ~isld, 1'b0, ra, $urandom, rf3, "rand", st, ac);
    end
    waitDrain("rand");
    checkOutput("rand writes all seen", exp_wr.size(), 0);

    $display("[TB] reset during drain");
    cache_wait = 6;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'hCAFE_F00D, 3'b010, "sw reset", st, ac);
    n = 0;
    @(negedge clk);
    #1;
    while (!(bus.dc_write && bus.dc_busywait) && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    checkOutput("drain in flight before reset", {31'h0, bus.dc_write}, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset dc_write drop", {31'h0, bus.dc_write}, 0);
    checkOutput("reset sb_count drop", {29'h0, bus.sb_count}, 0);
    checkOutput("reset busywait drop", {31'h0, bus.mem_busywait}, 0);
    exp_wr.delete();
    mark = wr_done;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("no write after reset", wr_done, mark);
    checkOutput("dc_write idle after reset", {31'h0, bus.dc_write}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_store_buffer_unit.md
# mem_store_buffer_unit

Memory-stage unit for the RV32IM pipeline that sits between the EX/MEM register and the data cache. It generalises the memory stage with a parametrised-depth store buffer so stores retire without waiting on the cache. It forwards buffered store data to younger loads, performs RV32 byte/half/word alignment and load extension, and drains the buffer to the cache through a busywait handshake. It replaces the direct cache connection; the cache controller is unchanged.

## Interface
- SB_DEPTH, 4: store-buffer entries; power of two, at least 2
- ADDR_W, 32: byte-address width
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- MEM_READ_EN  in  1  load in MEM stage (from EX/MEM)
- MEM_WRITE_EN  in  1  store in MEM stage
- FENCE  in  1  FENCE in MEM stage; stall until the buffer is empty
- ADDR  in  ADDR_W  byte address (ALU result)
- WRITE_DATA  in  32  store data, already forwarded, right-aligned
- FUNC3  in  3  access size and sign (RV32 load/store encoding)
- READ_DATA  out  32  extended load result
- MEM_BUSYWAIT  out  1  stall request to the pipeline
- MISALIGN  out  1  access is misaligned or has an illegal FUNC3; combinational
- SB_COUNT  out  $clog2(SB_DEPTH)+1  occupied entries
- DC_READ, DC_WRITE  out  1  cache request strobes
- DC_ADDR  out  ADDR_W  word address, low 2 bits zero
- DC_WRITEDATA  out  32  lane-aligned write data
- DC_BYTE_EN  out  4  byte lane enables for writes
- DC_READDATA  in  32  cache read word
- DC_BUSYWAIT  in  1  cache busy; the request is held while it is 1

## Operation
- **Entry format:** {word addr, 32-bit lane data, 4-bit BE}. The buffer is a circular FIFO with head and tail pointers. Entries are never coalesced.
- **Store alignment:**
  - SB: BE=1<<ADDR[1:0], data={4{WRITE_DATA[7:0]}}.
  - SH: BE=4'b0011<<ADDR[1:0], data={2{WRITE_DATA[15:0]}}.
  - SW: BE=4'hF.
- **Misaligned or illegal access:** SH/LH/LHU with ADDR[0]=1, SW/LW with ADDR[1:0]≠0, or any undefined FUNC3.
  - MISALIGN=1.
  - No enqueue and no cache access.
  - READ_DATA=0.
  - No stall.
- **Store:** enqueues at the clock edge when SB_COUNT<SB_DEPTH. If the buffer is full, MEM_BUSYWAIT=1. Fullness uses the registered count, so a pop in the same cycle does not admit the store until the next cycle.
- **Load:** all valid entries are compared against ADDR[ADDR_W-1:2].
  - **Hit:** the youngest matching entry's BE covers every needed byte. READ_DATA is formed from that entry in the same cycle, with no stall and no cache access.
  - **Partial:** a match exists but the youngest matching entry does not cover every needed byte. MEM_BUSYWAIT=1 and draining continues until no entry matches, then the load is handled as a miss.
  - **Miss:** no entry matches. MEM_BUSYWAIT=1 and a cache read is issued.
- **Load extension:**
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - The byte or half is selected by ADDR[1:0].
- **FSM states:** IDLE, DRAIN, LOAD, LDONE.
  - IDLE → LOAD: a miss load is pending; this has priority over draining.
  - IDLE → DRAIN: the buffer is non-empty and no miss load is pending.
  - DRAIN: DC_WRITE=1 with the head entry. At the first edge with DC_BUSYWAIT=0 the head is popped → IDLE.
  - LOAD: DC_READ=1 at DC_ADDR. At the first edge with DC_BUSYWAIT=0, DC_READDATA is captured → LDONE.
  - LDONE: READ_DATA comes from the captured word, MEM_BUSYWAIT=0 → IDLE.
- **No request aborts:** a drain already in progress always completes before LOAD.
- **FENCE:** MEM_BUSYWAIT=1 while SB_COUNT≠0 or state≠IDLE.
- **Busywait terms:** MEM_BUSYWAIT is the OR of the full-store, partial, miss (state≠LDONE) and FENCE terms.

## Timing
- **Reset (RESET=0, asynchronous):** takes effect immediately.
  - Pointers and count are 0; state is IDLE.
  - DC_READ=DC_WRITE=0, DC_ADDR=0, DC_WRITEDATA=0, DC_BYTE_EN=0.
  - The captured load word is 0, so READ_DATA=0.
  - MEM_BUSYWAIT=0, MISALIGN=0, SB_COUNT=0.
  - Buffered stores are discarded, and an in-flight request is dropped in the same cycle.
- **Cache handshake:** request outputs are registered from state and head. They are stable while DC_BUSYWAIT=1. Completion is the rising edge where a strobe is 1 and DC_BUSYWAIT=0.
- **Latency:**
  - Store: 0 stall cycles unless the buffer is full.
  - Forwarded load: 0 cycles.
  - Miss load: 1 cycle to enter LOAD, plus the cache cycles, plus 1 LDONE cycle.
- **Simultaneous enqueue and pop:** both occur and SB_COUNT is unchanged.
- **Wrap-around:** pointers wrap modulo SB_DEPTH, and drain order equals enqueue order.

## Test plan
- **Store-to-load forward:** SW 0x100=0xDEADBEEF, next cycle LW 0x100 → READ_DATA=0xDEADBEEF, MEM_BUSYWAIT=0, DC_READ stays 0.
- **Byte forward and partial hazard:** SB 0x103=0x80.
  - LB 0x103 → 0xFFFFFF80.
  - LBU 0x103 → 0x00000080.
  - LH 0x102 → stall, drain DC_WRITE BE=4'b1000, then DC_READ 0x100.
- **Full buffer (SB_DEPTH=4):** five back-to-back SW with DC_BUSYWAIT=1 for 3 cycles per write.
  - The fifth store sees MEM_BUSYWAIT=1 until the cycle after the first pop.
  - DC writes occur in program order across pointer wrap.
- **Misaligned access:** LW 0x102 → MISALIGN=1, READ_DATA=0, no stall, no DC strobe.
- **FENCE:** FENCE with 2 entries buffered → MEM_BUSYWAIT=1 until SB_COUNT=0 and IDLE, then 0.
- **Reset mid-drain:** drive RESET=0 while DC_WRITE=1 and DC_BUSYWAIT=1 → DC_WRITE=0 and SB_COUNT=0 immediately; no further writes after RESET returns to 1.
